// File: rtl/alu_serial_pkg.sv
// Shared encodings and helpers for the bit-serial ALU sequencer.
// Holds op codes, FSM states and the counter width function.
package alu_serial_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// Right-shifting register with parallel load, serial in at MSB, serial out at LSB.
// Latency: one cycle per load or shift.
// Backpressure: none; the register holds whenever load and shift are both low.
module serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU, LSB first; optional ovf via ALU_SERIAL_OVF_EN.
// Latency: WIDTH cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; a start held in the done cycle is accepted.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_f1,
  output logic             alu_f0,
  input  logic             alu_res,
  input  logic             alu_cout
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            carry_q;
  logic            cout_q;
  logic            accept;
  logic            shift_en;
  logic            last_bit;
  logic            arith;

  logic             a_sout, b_sout, res_sout;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             shreg_unused;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_bit = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // and/or never propagate a carry
  assign arith = ~op_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op;
        cnt_q   <= '0;
        carry_q <= (op == OP_SUB);
      end else if (shift_en) begin
        cnt_q   <= cnt_q + CW'(1);
        carry_q <= arith & alu_cout;
        if (last_bit) cout_q <= arith & alu_cout;
      end
    end
  end

  serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(a),
    .shift(shift_en), .sin(1'b0), .sout(a_sout), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(b),
    .shift(shift_en), .sin(1'b0), .sout(b_sout), .q(b_q)
  );

  // result is never cleared on start; WIDTH shifts fully replace it
  serial_shreg #(.WIDTH(WIDTH)) u_res_sh (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
    .shift(shift_en), .sin(alu_res), .sout(res_sout), .q(res_q)
  );

  // taps of the shared shift register this controller has no use for
  assign shreg_unused = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], res_sout};

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;

  // carry into the MSB is carry_q during the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= arith & (carry_q ^ alu_cout);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign result  = res_q;
  assign cout    = cout_q;
  assign alu_a   = shift_en & a_sout;
  assign alu_b   = shift_en & b_sout;
  assign alu_cin = shift_en & carry_q;
  assign alu_f1  = shift_en & op_q[1];
  assign alu_f0  = shift_en & op_q[0];

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit ALU alongside.
module tb_alu_serial_ctrl;
  import alu_serial_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;
  logic             alu_a, alu_b, alu_cin, alu_f1, alu_f0;
  logic             alu_res, alu_cout;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf;
`endif

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f1(alu_f1), .alu_f0(alu_f0),
    .alu_res(alu_res), .alu_cout(alu_cout)
`ifdef ALU_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice
  logic       bsel;
  logic [1:0] sum;
  always_comb begin
    bsel = alu_f0 ? ~alu_b : alu_b;
    sum  = {1'b0, alu_a} + {1'b0, bsel} + {1'b0, alu_cin};
    case ({alu_f1, alu_f0})
      2'b10:   begin alu_res = alu_a & alu_b; alu_cout = 1'b0; end
      2'b11:   begin alu_res = alu_a | alu_b; alu_cout = 1'b0; end
      default: begin alu_res = sum[0];        alu_cout = sum[1]; end
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    int               start_cyc;
    int               id;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: compares each done against the oldest expected entry
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("op%0d_result", e.id), 32'(result), 32'(e.res));
          check($sformatf("op%0d_cout", e.id), 32'(cout), 32'(e.cout));
`ifdef ALU_SERIAL_OVF_EN
          check($sformatf("op%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
`endif
          check($sformatf("op%0d_latency", e.id), 32'(cyc - e.start_cyc), 32'(WIDTH));
          check($sformatf("op%0d_busy_cycles", e.id), 32'(busy_run), 32'(WIDTH));
          check($sformatf("op%0d_busy_in_done", e.id), 32'(busy), 32'd0);
        end
        busy_run = 0;
      end
      if (!busy)
        check("alu_drive_idle", 32'({alu_a, alu_b, alu_cin, alu_f1, alu_f0}), 32'd0);
      else if (alu_f1)
        check("logic_op_cin", 32'(alu_cin), 32'd0);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] r, input logic c, input logic v, input int id);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back('{res: r, cout: c, ovf: v, start_cyc: cyc + 1, id: id});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},   32'(busy),   32'd0);
    check({name, "_done"},   32'(done),   32'd0);
    check({name, "_result"}, 32'(result), 32'd0);
    check({name, "_cout"},   32'(cout),   32'd0);
    check({name, "_alu"},    32'({alu_a, alu_b, alu_cin, alu_f1, alu_f0}), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
    check({name, "_ovf"},    32'(ovf),    32'd0);
`endif
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(OP_ADD, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1);  wait_drain();
    issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 2);  wait_drain();
    issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 3);  wait_drain();
    issue(OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 4);  wait_drain();
    issue(OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 5);  wait_drain();
    issue(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 6);  wait_drain();
    issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 7);  wait_drain();
    issue(OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 8);  wait_drain();

    // start pulse during SHIFT must be ignored
    issue(OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 9);
    repeat (2) @(negedge clk);
    start = 1'b1; op = OP_SUB; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check("hold_result", 32'(result), 32'h46);

    // back-to-back: start held in the DONE cycle
    issue(OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 10);
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    start = 1'b1; op = OP_OR; a = 8'h0F; b = 8'hF0;
    sb_q.push_back('{res: 8'hFF, cout: 1'b0, ovf: 1'b0, start_cyc: cyc + 1, id: 11});
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // reset after bit 4 of an ADD
    issue(OP_ADD, 8'h55, 8'h0F, 8'h64, 1'b0, 1'b0, 12);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_SUB, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 13);  wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
